axi_sram_slave: RTL and testbench

//  AXI3 slave (responder) backed by an on-chip single-port word RAM; completes the read/write

---
 rtl/axi_pkg.sv | 16 +
 rtl/sp_ram_bw.sv | 24 ++
 rtl/axi_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response codes, FSM state types
// and the word-address range check used by both channels.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_RD, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // A word address is backed by RAM only if nothing is set above the RAM index bits.
  function automatic logic word_in_range(input logic [29:0] waddr, input int aw);
    return (waddr >> aw) == 30'd0;
  endfunction

endpackage

// File: rtl/sp_ram_bw.sv
// Single-port word RAM with per-byte write enables and a one-cycle synchronous read.
// The read register only updates on a read, so it holds its value across write cycles.
module sp_ram_bw #(
  parameter int    MEM_AW   = 14,
  parameter string INIT_HEX = ""
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [MEM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving INCR bursts from a single-port RAM; independent read and
// write FSMs share the RAM port, with write beats taking priority.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int    MEM_AW   = 14,
  parameter int    ID_W     = 4,
  parameter string INIT_HEX = ""
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  r_state_e    r_state;
  w_state_e    w_state;
  logic [29:0] r_waddr, w_waddr;
  logic [3:0]  r_len, r_cnt, w_len, w_cnt;
  logic        r_hit, w_err;
  logic        w_beat, r_issue, r_ok, w_ok;
  logic        ram_re;
  logic [3:0]  ram_be;
  logic [MEM_AW-1:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        unused_bits;

  assign unused_bits = ^{araddr[1:0], awaddr[1:0], arlen[7:4], awlen[7:4]};

  // Port arbitration: a write beat owns the RAM; a pending read waits in R_RD.
  assign w_beat   = wvalid && wready;
  assign r_issue  = (r_state == R_RD) && !w_beat;
  assign r_ok     = word_in_range(r_waddr, MEM_AW);
  assign w_ok     = word_in_range(w_waddr, MEM_AW);
  assign ram_re   = r_issue && r_ok;
  assign ram_be   = (w_beat && w_ok) ? wstrb : 4'b0000;
  assign ram_addr = w_beat ? w_waddr[MEM_AW-1:0] : r_waddr[MEM_AW-1:0];
  assign rdata    = r_hit ? ram_rdata : 32'h0;

  sp_ram_bw #(.MEM_AW(MEM_AW), .INIT_HEX(INIT_HEX)) u_ram (
    .clk   (aclk),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      r_hit   <= 1'b0;
      r_waddr <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            r_waddr <= araddr[31:2];
            r_len   <= arlen[3:0];
            r_cnt   <= '0;
            r_state <= R_RD;
          end
        end
        R_RD: begin
          if (r_issue) begin
            r_hit   <= r_ok;
            rresp   <= r_ok ? RESP_OKAY : RESP_DECERR;
            rlast   <= (r_cnt == r_len);
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_waddr <= r_waddr + 30'd1;
              r_cnt   <= r_cnt + 4'd1;
              r_state <= R_RD;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // The burst length comes from awlen alone; the error flag is sticky over the burst.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_err   <= 1'b0;
      w_waddr <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            w_waddr <= awaddr[31:2];
            w_len   <= awlen[3:0];
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_waddr <= w_waddr + 30'd1;
            w_cnt   <= w_cnt + 4'd1;
            if (!w_ok) w_err <= 1'b1;
            if (w_cnt == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || !w_ok) ? RESP_DECERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed table, hand-written corner
// sequences and randomized bursts checked against a byte-level memory model.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int MEM_AW = 14;
  localparam int ID_W   = 4;
  localparam int TMO    = 200;

  logic            aclk = 1'b0;
  logic            areset;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [1:0]      rresp, bresp;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]      wstrb;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.MEM_AW(MEM_AW), .ID_W(ID_W), .INIT_HEX("")) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference memory: word contents plus which bytes have ever been written.
  logic [31:0] mData  [int];
  logic [3:0]  mKnown [int];
  logic [31:0] wBuf [16];
  logic [3:0]  sBuf [16];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data0;
    logic [3:0]  strb;
    logic [1:0]  expB;
    logic [31:0] expRd0;
    int          rmode;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp, input logic [31:0] mask);
    if (mask != 32'h0) begin
      nCompared++;
      if ((act & mask) !== (exp & mask)) begin
        nMismatched++;
        $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (mask 0x%08h) at %0t",
                 name, act, exp, mask, $time);
      end
    end
  endtask

  task automatic timeoutFail(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: timed out after %0d cycles at %0t", name, TMO, $time);
  endtask

  function automatic bit inRange(input logic [31:0] a);
    return a < (32'd4 << MEM_AW);
  endfunction

  function automatic logic [31:0] byteMask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    if (inRange(a)) begin
      w = int'(a >> 2);
      if (!mData.exists(w)) begin
        mData[w]  = 32'h0;
        mKnown[w] = 4'h0;
      end
      for (int i = 0; i < 4; i++) if (s[i]) mData[w][8*i +: 8] = d[8*i +: 8];
      mKnown[w] = mKnown[w] | s;
    end
  endtask

  task automatic modelRead(input logic [31:0] a, output logic [31:0] d,
                           output logic [31:0] m, output logic [1:0] r);
    int w;
    if (inRange(a)) begin
      w = int'(a >> 2);
      d = mData.exists(w) ? mData[w] : 32'h0;
      m = mKnown.exists(w) ? byteMask(mKnown[w]) : 32'h0;
      r = RESP_OKAY;
    end else begin
      d = 32'h0;
      m = 32'hFFFF_FFFF;
      r = RESP_DECERR;
    end
  endtask

  // All transaction tasks start and end on a falling edge.
  task automatic doWrite(input logic [31:0] addr, input logic [7:0] len,
                         input logic [ID_W-1:0] id, input bit gaps, output logic [1:0] resp);
    int t;
    int beats = int'(len[3:0]) + 1;
    logic [1:0] expResp = RESP_OKAY;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    t = 0;
    while (!awready && t < TMO) begin @(negedge aclk); t++; end
    if (t >= TMO) timeoutFail("awready");
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b < beats; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b0;
        @(negedge aclk);
      end
      wvalid = 1'b1; wdata = wBuf[b]; wstrb = sBuf[b];
      t = 0;
      while (!wready && t < TMO) begin @(negedge aclk); t++; end
      if (t >= TMO) timeoutFail("wready");
      @(negedge aclk);
      modelWrite(addr + 32'(4*b), wBuf[b], sBuf[b]);
      if (!inRange(addr + 32'(4*b))) expResp = RESP_DECERR;
      if (b == beats - 1) checkOutput("bEarliest", 32'(bvalid), 32'd1, 32'h1);
    end
    wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < TMO) begin @(negedge aclk); t++; end
    if (t >= TMO) timeoutFail("bvalid");
    checkOutput("bresp", 32'(bresp), 32'(expResp), 32'h3);
    checkOutput("bid", 32'(bid), 32'(id), 32'hF);
    resp = bresp;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  // rmode 0: rready always high, 1: one stall cycle per beat, 2: random stalls.
  task automatic doRead(input logic [31:0] addr, input logic [7:0] len, input logic [ID_W-1:0] id,
                        input int rmode, output logic [31:0] first);
    int t, lat, stalls;
    int beats = int'(len[3:0]) + 1;
    logic [31:0] ed, em, held;
    logic [1:0]  er;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin @(negedge aclk); t++; end
    if (t >= TMO) timeoutFail("arready");
    @(negedge aclk);
    arvalid = 1'b0;
    lat = 1;
    first = 32'h0;
    for (int b = 0; b < beats; b++) begin
      t = 0;
      while (!rvalid && t < TMO) begin @(negedge aclk); t++; lat++; end
      if (t >= TMO) timeoutFail("rvalid");
      if (b == 0) checkOutput("rLatency", 32'(lat), 32'd2, 32'hFFFF_FFFF);
      modelRead(addr + 32'(4*b), ed, em, er);
      stalls = (rmode == 1) ? 1 : (rmode == 2) ? int'($urandom_range(0, 2)) : 0;
      while (stalls > 0) begin
        rready = 1'b0;
        held = rdata;
        @(negedge aclk);
        checkOutput("rHoldData", rdata, held, 32'hFFFF_FFFF);
        checkOutput("rHoldValid", 32'(rvalid), 32'd1, 32'h1);
        stalls--;
      end
      rready = 1'b1;
      if (b == 0) first = rdata;
      checkOutput("rdata", rdata, ed, em);
      checkOutput("rresp", 32'(rresp), 32'(er), 32'h3);
      checkOutput("rlast", 32'(rlast), (b == beats - 1) ? 32'd1 : 32'd0, 32'h1);
      checkOutput("rid", 32'(rid), 32'(id), 32'hF);
      @(negedge aclk);
      rready = 1'b0;
      lat = 0;
    end
    checkOutput("rDone", 32'(rvalid), 32'd0, 32'h1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [1:0]  br;
    logic [31:0] first;
    for (int b = 0; b < 16; b++) begin
      wBuf[b] = v.data0 + 32'(b);
      sBuf[b] = v.strb;
    end
    doWrite(v.addr, v.len, ID_W'($urandom_range(0, 15)), 1'b0, br);
    checkOutput("tableBresp", 32'(br), 32'(v.expB), 32'h3);
    doRead(v.addr, v.len, ID_W'($urandom_range(0, 15)), v.rmode, first);
    checkOutput("tableRd0", first, v.expRd0, 32'hFFFF_FFFF);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  br;
    logic [31:0] first, a;
    logic [7:0]  l;
    int t, beats;

    vecs[0] = '{32'h100,   8'd0,  32'hDEADBEEF, 4'hF, RESP_OKAY,   32'hDEADBEEF, 0};
    vecs[1] = '{32'h100,   8'd0,  32'h0000AA00, 4'h2, RESP_OKAY,   32'hDEADAAEF, 0};
    vecs[2] = '{32'h200,   8'd3,  32'h1,        4'hF, RESP_OKAY,   32'h1,        1};
    vecs[3] = '{32'h0,     8'd0,  32'hCAFEF00D, 4'hF, RESP_OKAY,   32'hCAFEF00D, 0};
    vecs[4] = '{32'h10000, 8'd0,  32'h12345678, 4'hF, RESP_DECERR, 32'h0,        0};
    vecs[5] = '{32'hFFFC,  8'd1,  32'h55AA0000, 4'hF, RESP_DECERR, 32'h55AA0000, 2};
    vecs[6] = '{32'h300,   8'd15, 32'h3000,     4'hF, RESP_OKAY,   32'h3000,     2};
    vecs[7] = '{32'h400,   8'h13, 32'h4000,     4'hF, RESP_OKAY,   32'h4000,     0};
    vecs[8] = '{32'h500,   8'd0,  32'h77777777, 4'hF, RESP_OKAY,   32'h77777777, 0};
    vecs[9] = '{32'h500,   8'd0,  32'h99999999, 4'h0, RESP_OKAY,   32'h77777777, 0};

    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge aclk);

    checkOutput("rstArready", 32'(arready), 32'd0, 32'h1);
    checkOutput("rstAwready", 32'(awready), 32'd0, 32'h1);
    checkOutput("rstRvalid",  32'(rvalid),  32'd0, 32'h1);
    checkOutput("rstWready",  32'(wready),  32'd0, 32'h1);
    checkOutput("rstBvalid",  32'(bvalid),  32'd0, 32'h1);
    checkOutput("rstRid",     32'(rid),     32'd0, 32'hF);
    checkOutput("rstBid",     32'(bid),     32'd0, 32'hF);
    checkOutput("rstRdata",   rdata,        32'd0, 32'hFFFF_FFFF);
    checkOutput("rstRresp",   32'(rresp),   32'd0, 32'h3);
    checkOutput("rstBresp",   32'(bresp),   32'd0, 32'h3);
    checkOutput("rstRlast",   32'(rlast),   32'd0, 32'h1);

    areset = 1'b0;
    wvalid = 1'b1; wdata = 32'hBAD0BAD0; wstrb = 4'hF;
    @(negedge aclk);
    checkOutput("idleArready", 32'(arready), 32'd1, 32'h1);
    checkOutput("idleAwready", 32'(awready), 32'd1, 32'h1);
    checkOutput("idleWready",  32'(wready),  32'd0, 32'h1);
    @(negedge aclk);
    checkOutput("idleWready2", 32'(wready),  32'd0, 32'h1);
    wvalid = 1'b0;

    $display("[TB] directed table");
    foreach (vecs[i]) applyStimulus(vecs[i]);
    doRead(32'h0, 8'd0, 4'd1, 0, first);
    checkOutput("oobWriteDropped", first, 32'hCAFEF00D, 32'hFFFF_FFFF);

    $display("[TB] simultaneous AR/AW to one address");
    wBuf[0] = 32'h11111111; sBuf[0] = 4'hF;
    doWrite(32'h600, 8'd0, 4'd1, 1'b0, br);
    arid = 4'd3; araddr = 32'h600; arlen = 8'd0; arvalid = 1'b1;
    awid = 4'd5; awaddr = 32'h600; awlen = 8'd0; awvalid = 1'b1;
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    checkOutput("simArready", 32'(arready), 32'd1, 32'h1);
    checkOutput("simAwready", 32'(awready), 32'd1, 32'h1);
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    checkOutput("simWready", 32'(wready), 32'd1, 32'h1);
    @(negedge aclk);
    wvalid = 1'b0;
    modelWrite(32'h600, 32'hA5A5A5A5, 4'hF);
    checkOutput("simReadStalled", 32'(rvalid), 32'd0, 32'h1);
    checkOutput("simBvalid", 32'(bvalid), 32'd1, 32'h1);
    checkOutput("simBid", 32'(bid), 32'd5, 32'hF);
    @(negedge aclk);
    checkOutput("simRvalid", 32'(rvalid), 32'd1, 32'h1);
    checkOutput("simRdata", rdata, 32'hA5A5A5A5, 32'hFFFF_FFFF);
    checkOutput("simRid", 32'(rid), 32'd3, 32'hF);
    checkOutput("simRlast", 32'(rlast), 32'd1, 32'h1);
    checkOutput("simBresp", 32'(bresp), 32'(RESP_OKAY), 32'h3);
    rready = 1'b1; bready = 1'b1;
    @(negedge aclk);
    rready = 1'b0; bready = 1'b0;

    $display("[TB] reset during an 8-beat read");
    for (int b = 0; b < 16; b++) begin
      wBuf[b] = 32'h7000 + 32'(b);
      sBuf[b] = 4'hF;
    end
    doWrite(32'h700, 8'd7, 4'd2, 1'b0, br);
    arid = 4'd6; araddr = 32'h700; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin @(negedge aclk); t++; end
    @(negedge aclk);
    arvalid = 1'b0;
    beats = 0; t = 0;
    while (beats < 3 && t < TMO) begin
      @(negedge aclk);
      t++;
      if (rvalid) beats++;
    end
    if (t >= TMO) timeoutFail("rstBurstBeats");
    areset = 1'b1; rready = 1'b0;
    @(negedge aclk);
    checkOutput("midRstRvalid",  32'(rvalid),  32'd0, 32'h1);
    checkOutput("midRstArready", 32'(arready), 32'd0, 32'h1);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("postRstArready", 32'(arready), 32'd1, 32'h1);
    checkOutput("postRstRvalid",  32'(rvalid),  32'd0, 32'h1);
    doRead(32'h700, 8'd7, 4'd6, 0, first);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) a = 32'hFFC0 + 32'(4 * $urandom_range(0, 31));
      else                           a = 32'h800 + 32'(4 * $urandom_range(0, 63));
      l = 8'($urandom_range(0, 255));
      for (int b = 0; b < 16; b++) begin
        wBuf[b] = $urandom;
        sBuf[b] = 4'($urandom_range(0, 15));
      end
      doWrite(a, l, ID_W'($urandom_range(0, 15)), 1'b1, br);
      if ($urandom_range(0, 1) == 1) a = 32'h800 + 32'(4 * $urandom_range(0, 63));
      doRead(a, 8'($urandom_range(0, 255)), ID_W'($urandom_range(0, 15)), 2, first);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
